// File: rtl/bitserial_alu.sv
// Multi-column bit-serial add/sub/xor/and unit fed by sensed BL/BLB pairs, LSB first.
// A per-column carry latch spans bit positions; start/done sequences one operation.
module bitserial_alu #(
  parameter int COLS = 8,
  parameter int LENW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [LENW-1:0] op_len,
  input  logic            abort,
  input  logic            bit_valid,
  input  logic [COLS-1:0] bl,
  input  logic [COLS-1:0] blb,
  output logic            busy,
  output logic [COLS-1:0] sum,
  output logic            sum_valid,
  output logic            done,
  output logic [COLS-1:0] cout,
  output logic [COLS-1:0] ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;

  state_e          state_q, state_d;
  logic [1:0]      mode_q;
  logic [LENW-1:0] len_q, cnt_q;
  logic [COLS-1:0] carry_q, sum_q, cout_q, ovf_q;
  logic            sum_valid_q;

  logic [COLS-1:0] x, g, s, c_nxt;
  logic            arith, accept, last, start_ok;

  // BL high means both cells store 1, BLB high means both store 0; neither means they differ.
  always_comb begin
    x     = ~(bl | blb);
    g     = bl;
    arith = ~mode_q[1];
    if (arith) begin
      s     = x ^ carry_q;
      c_nxt = g | (x & carry_q);
    end else begin
      s     = (mode_q == M_XOR) ? x : g;
      c_nxt = '0;
    end
  end

  assign start_ok = (state_q == S_IDLE) && start && (op_len != '0);
  assign accept   = (state_q == S_RUN) && bit_valid;
  assign last     = accept && (cnt_q == len_q - LENW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      cout_q      <= '0;
      ovf_q       <= '0;
    end else begin
      // A bit accepted alongside abort still reports its sum.
      sum_valid_q <= accept;
      if (accept) sum_q <= s;
      if (start_ok) begin
        mode_q  <= mode;
        len_q   <= op_len;
        cnt_q   <= '0;
        carry_q <= {COLS{mode == M_SUB}};
      end else if (abort && state_q != S_IDLE) begin
        carry_q <= '0;
      end else if (accept) begin
        carry_q <= c_nxt;
        cnt_q   <= cnt_q + LENW'(1);
        if (last) begin
          cout_q <= c_nxt;
          ovf_q  <= arith ? (carry_q ^ c_nxt) : '0;
        end
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH) && !abort;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bitserial_alu.sv
// Self-checking bench for bitserial_alu: random operands per column checked against
// an integer-arithmetic reference model, plus directed protocol corner cases.
module tb_bitserial_alu;
  localparam int COLS = 8;
  localparam int LENW = 5;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, XOR = 2'b10, AND = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n, start, abort, bit_valid;
  logic [1:0]      mode;
  logic [LENW-1:0] op_len;
  logic [COLS-1:0] bl, blb, sum, cout, ovf;
  logic            busy, sum_valid, done;

  int errors = 0;
  int checks = 0;

  longint unsigned a_v[COLS], b_v[COLS], exp_sum[COLS], got_sum[COLS], save_sum[COLS];
  logic            exp_cout[COLS], exp_ovf[COLS];
  logic [1:0]      cur_mode;
  int              cur_len;
  int              pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  bitserial_alu #(.COLS(COLS), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .op_len(op_len),
    .abort(abort), .bit_valid(bit_valid), .bl(bl), .blb(blb), .busy(busy),
    .sum(sum), .sum_valid(sum_valid), .done(done), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-word arithmetic on the true operands.
  function automatic void model();
    longint unsigned mask, a, b, full;
    logic sa, sb, sr;
    mask = (64'd1 << cur_len) - 64'd1;
    for (int c = 0; c < COLS; c++) begin
      a = a_v[c] & mask;
      b = b_v[c] & mask;
      case (cur_mode)
        ADD:     full = a + b;
        SUB:     full = a + (~b & mask) + 64'd1;
        XOR:     full = a ^ b;
        default: full = a & b;
      endcase
      exp_sum[c] = full & mask;
      sa = a[cur_len-1];
      sb = b[cur_len-1];
      sr = exp_sum[c][cur_len-1];
      exp_cout[c] = 1'b0;
      exp_ovf[c]  = 1'b0;
      if (cur_mode == ADD) begin
        exp_cout[c] = full[cur_len];
        exp_ovf[c]  = (sa == sb) && (sr != sa);
      end else if (cur_mode == SUB) begin
        exp_cout[c] = full[cur_len];
        exp_ovf[c]  = (sa != sb) && (sr != sa);
      end
    end
  endfunction

  task automatic rand_operands(input int len);
    longint unsigned mask;
    mask = (64'd1 << len) - 64'd1;
    for (int c = 0; c < COLS; c++) begin
      a_v[c] = longint'($urandom) & mask;
      b_v[c] = longint'($urandom) & mask;
    end
  endtask

  // The array row holds ~B for subtraction.
  task automatic set_bit(input int k, input logic v);
    logic ab, bb;
    for (int c = 0; c < COLS; c++) begin
      ab = a_v[c][k];
      bb = (cur_mode == SUB) ? ~b_v[c][k] : b_v[c][k];
      bl[c]  = ab & bb;
      blb[c] = ~ab & ~bb;
    end
    bit_valid = v;
  endtask

  task automatic start_op(input logic [1:0] m, input int len);
    logic [LENW-1:0] l;
    l = LENW'(len);
    cur_mode = m;
    cur_len  = len;
    model();
    mode   = m;
    op_len = l;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] m, input int len, input int gap_mode, input bit poke);
    int k, cyc, pi, nvalid;
    logic v;
    k = 0; cyc = 0; pi = 0; nvalid = 0;
    start_op(m, len);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
    for (int c = 0; c < COLS; c++) got_sum[c] = 0;
    while (k < len && cyc < 400) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = 1'(($urandom_range(0, 2) != 0));
        default: begin v = 1'(pat[pi % 7]); pi++; end
      endcase
      set_bit(k, v);
      if (poke && cyc == 1) begin start = 1'b1; mode = ~m; op_len = LENW'(2); end
      @(posedge clk); #1;
      start = 1'b0; bit_valid = 1'b0; mode = m;
      checks++;
      if (sum_valid !== v) begin errors++; $display("FAIL sum_valid bit%0d: got %b expected %b", k, sum_valid, v); end
      if (v) begin
        for (int c = 0; c < COLS; c++) got_sum[c][k] = sum[c];
        k++;
        nvalid++;
      end
      checks++;
      if (done !== (k == len)) begin errors++; $display("FAIL done_timing bit%0d: got %b expected %b", k, done, (k == len)); end
      cyc++;
    end
    checks++;
    if (k < len) begin errors++; $display("FAIL op_timeout: got %0d bits expected %0d", k, len); end
    checks++;
    if (nvalid != len) begin errors++; $display("FAIL sum_valid_count: got %0d expected %0d", nvalid, len); end
    for (int c = 0; c < COLS; c++) begin
      checks++;
      if (got_sum[c] !== exp_sum[c] || cout[c] !== exp_cout[c] || ovf[c] !== exp_ovf[c]) begin
        errors++;
        $display("FAIL result m%0d len%0d col%0d: got sum=%0h cout=%b ovf=%b expected sum=%0h cout=%b ovf=%b",
                 m, len, c, got_sum[c], cout[c], ovf[c], exp_sum[c], exp_cout[c], exp_ovf[c]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL finish_exit: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, sum, sum_valid, done, cout, ovf} !== '0) begin
      errors++; $display("FAIL reset_values: got busy=%b sum=%h sv=%b done=%b cout=%h ovf=%h expected all 0",
                         busy, sum, sum_valid, done, cout, ovf);
    end
  endtask

  task automatic test_add();
    rand_operands(4);
    a_v[0] = 5; b_v[0] = 3; a_v[1] = 1; b_v[1] = 1;
    run_op(ADD, 4, 0, 0);
    checks++;
    if (got_sum[0] !== 8 || cout[0] !== 1'b0 || ovf[0] !== 1'b1)
      begin errors++; $display("FAIL add_col0: got sum=%0d cout=%b ovf=%b expected 8 0 1", got_sum[0], cout[0], ovf[0]); end
    checks++;
    if (got_sum[1] !== 2 || cout[1] !== 1'b0 || ovf[1] !== 1'b0)
      begin errors++; $display("FAIL add_col1: got sum=%0d cout=%b ovf=%b expected 2 0 0", got_sum[1], cout[1], ovf[1]); end
  endtask

  task automatic test_sub();
    rand_operands(4);
    a_v[0] = 6; b_v[0] = 2; a_v[1] = 2; b_v[1] = 6;
    run_op(SUB, 4, 0, 0);
    checks++;
    if (got_sum[0] !== 4 || cout[0] !== 1'b1 || ovf[0] !== 1'b0)
      begin errors++; $display("FAIL sub_col0: got sum=%0d cout=%b ovf=%b expected 4 1 0", got_sum[0], cout[0], ovf[0]); end
    checks++;
    if (got_sum[1] !== 12 || cout[1] !== 1'b0 || ovf[1] !== 1'b0)
      begin errors++; $display("FAIL sub_col1: got sum=%0d cout=%b ovf=%b expected 12 0 0", got_sum[1], cout[1], ovf[1]); end
  endtask

  task automatic test_logic();
    for (int c = 0; c < COLS; c++) begin a_v[c] = 5; b_v[c] = 3; end
    run_op(XOR, 3, 0, 0);
    checks++;
    if (got_sum[3] !== 6 || cout !== '0 || ovf !== '0)
      begin errors++; $display("FAIL xor: got sum=%0d cout=%h ovf=%h expected 6 0 0", got_sum[3], cout, ovf); end
    run_op(AND, 3, 0, 0);
    checks++;
    if (got_sum[5] !== 1 || cout !== '0 || ovf !== '0)
      begin errors++; $display("FAIL and: got sum=%0d cout=%h ovf=%h expected 1 0 0", got_sum[5], cout, ovf); end
  endtask

  task automatic test_gaps();
    rand_operands(4);
    run_op(ADD, 4, 0, 0);
    for (int c = 0; c < COLS; c++) save_sum[c] = got_sum[c];
    run_op(ADD, 4, 2, 0);
    for (int c = 0; c < COLS; c++) begin
      checks++;
      if (got_sum[c] !== save_sum[c])
        begin errors++; $display("FAIL gap_vs_nogap col%0d: got %0h expected %0h", c, got_sum[c], save_sum[c]); end
    end
  endtask

  task automatic test_start_busy();
    rand_operands(5);
    run_op(ADD, 5, 0, 1);
  endtask

  task automatic test_len_zero();
    mode = ADD; op_len = '0; start = 1'b1; bit_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum_valid !== 1'b0)
        begin errors++; $display("FAIL len_zero: got busy=%b done=%b sv=%b expected 0 0 0", busy, done, sum_valid); end
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_abort(input logic with_bit);
    logic [COLS-1:0] expv;
    rand_operands(6);
    start_op(ADD, 6);
    set_bit(0, 1'b1); @(posedge clk); #1;
    set_bit(1, 1'b1); @(posedge clk); #1;
    set_bit(2, with_bit);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; bit_valid = 1'b0;
    for (int c = 0; c < COLS; c++) expv[c] = exp_sum[c][2];
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum_valid !== with_bit)
      begin errors++; $display("FAIL abort_exit: got busy=%b done=%b sv=%b expected 0 0 %b", busy, done, sum_valid, with_bit); end
    if (with_bit) begin
      checks++;
      if (sum !== expv) begin errors++; $display("FAIL abort_bit_sum: got %h expected %h", sum, expv); end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL abort_nodone: got done=%b busy=%b expected 0 0", done, busy); end
    end
  endtask

  task automatic test_max_len();
    for (int c = 0; c < COLS; c++) begin a_v[c] = 64'h7FFF_FFFF; b_v[c] = 1; end
    run_op(ADD, 31, 0, 0);
    for (int c = 0; c < COLS; c++) begin
      checks++;
      if (got_sum[c] !== 0 || cout[c] !== 1'b1 || ovf[c] !== 1'b0)
        begin errors++; $display("FAIL max_len col%0d: got sum=%0h cout=%b ovf=%b expected 0 1 0", c, got_sum[c], cout[c], ovf[c]); end
    end
  endtask

  task automatic test_reset_mid();
    rand_operands(8);
    start_op(ADD, 8);
    for (int k = 0; k < 3; k++) begin set_bit(k, 1'b1); @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, sum, sum_valid, done, cout, ovf} !== '0)
      begin errors++; $display("FAIL reset_mid: got busy=%b sum=%h sv=%b done=%b cout=%h ovf=%h expected all 0",
                               busy, sum, sum_valid, done, cout, ovf); end
    bit_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0] m;
    int len;
    for (int i = 0; i < 20; i++) begin
      m   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 31);
      rand_operands(len);
      run_op(m, len, 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    rand_operands(7);
    run_op(SUB, 7, 0, 0);
    rand_operands(3);
    run_op(ADD, 3, 1, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
    mode = '0; op_len = '0; bl = '0; blb = '0;
    #1 rst_n = 1'b0;
    #11;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_logic();
    test_gaps();
    test_start_busy();
    test_len_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_max_len();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
